// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: architectural HI/LO plus a fixed-latency busy window for md ops.
// Results are computed combinationally at issue, held in pending registers and retired when the countdown ends.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [4:0]  i_mduOp,
   input  logic        i_start,
   input  logic [31:0] i_A,
   input  logic [31:0] i_B,
   output logic        o_busy,
   output logic [31:0] o_HI,
   output logic [31:0] o_LO,
   output logic [31:0] o_result
);

   localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAXC + 1);

   localparam logic [4:0] OP_MULT  = 5'd1;
   localparam logic [4:0] OP_MULTU = 5'd2;
   localparam logic [4:0] OP_DIV   = 5'd3;
   localparam logic [4:0] OP_DIVU  = 5'd4;
   localparam logic [4:0] OP_MTLO  = 5'd5;
   localparam logic [4:0] OP_MTHI  = 5'd6;
   localparam logic [4:0] OP_MFLO  = 5'd7;
   localparam logic [4:0] OP_MFHI  = 5'd8;

   typedef enum logic {S_IDLE, S_BUSY} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;
   logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic               pend_wr_q, pend_wr_d;

   // Multiply datapath: operands widened to 64 bits so the low 64 product bits are exact.
   logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
   assign a_sx   = {{32{i_A[31]}}, i_A};
   assign b_sx   = {{32{i_B[31]}}, i_B};
   assign a_zx   = {32'd0, i_A};
   assign b_zx   = {32'd0, i_B};
   assign prod_s = a_sx * b_sx;
   assign prod_u = a_zx * b_zx;

   // One shared unsigned divider; signed ops divide magnitudes and fix the signs afterwards.
   // The 0x80000000 / -1 case falls out naturally: magnitude quotient 0x80000000, negated to itself.
   logic        signed_div, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, num, den, den_safe, q_u, r_u, quot, rem;
   assign signed_div = (i_mduOp == OP_DIV);
   assign a_neg      = i_A[31];
   assign b_neg      = i_B[31];
   assign a_mag      = a_neg ? (32'd0 - i_A) : i_A;
   assign b_mag      = b_neg ? (32'd0 - i_B) : i_B;
   assign num        = signed_div ? a_mag : i_A;
   assign den        = signed_div ? b_mag : i_B;
   assign den_safe   = (den == 32'd0) ? 32'd1 : den;
   assign q_u        = num / den_safe;
   assign r_u        = num % den_safe;
   assign quot       = (signed_div && (a_neg ^ b_neg)) ? (32'd0 - q_u) : q_u;
   assign rem        = (signed_div && a_neg) ? (32'd0 - r_u) : r_u;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               case (i_mduOp)
                  OP_MULT: begin
                     pend_hi_d = prod_s[63:32];
                     pend_lo_d = prod_s[31:0];
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = S_BUSY;
                  end
                  OP_MULTU: begin
                     pend_hi_d = prod_u[63:32];
                     pend_lo_d = prod_u[31:0];
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = S_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_d = rem;
                     pend_lo_d = quot;
                     // Divide by zero still occupies the unit but leaves HI/LO untouched.
                     pend_wr_d = (i_B != 32'd0);
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = S_BUSY;
                  end
                  OP_MTHI: hi_d = i_A;
                  OP_MTLO: lo_d = i_A;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_busy   = (state_q == S_BUSY);
   assign o_HI     = hi_q;
   assign o_LO     = lo_q;
   assign o_result = (i_mduOp == OP_MFHI) ? hi_q :
                     (i_mduOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table for md ops plus hand sequences for
// move-to/from, overlap-while-busy, divide by zero and mid-operation reset.
module tb_mult_div_unit;

   localparam logic [4:0] OP_DEF = 5'd0, OP_MULT = 5'd1, OP_MULTU = 5'd2, OP_DIV = 5'd3,
                          OP_DIVU = 5'd4, OP_MTLO = 5'd5, OP_MTHI = 5'd6, OP_MFLO = 5'd7,
                          OP_MFHI = 5'd8;

   logic        clk, rst, start, busy;
   logic [4:0]  op;
   logic [31:0] a, b, hi, lo, res;

   int checks = 0;
   int errors = 0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .i_clk(clk), .i_reset(rst), .i_mduOp(op), .i_start(start), .i_A(a), .i_B(b),
      .o_busy(busy), .o_HI(hi), .o_LO(lo), .o_result(res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a, b;
      int          cyc;
      logic [31:0] hi, lo;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Issue one op, then count busy cycles (sampled on negedges) while checking HI/LO hold.
   task automatic run_op(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] phi, input logic [31:0] plo, output int n);
      @(negedge clk);
      op = o; a = va; b = vb; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = OP_DEF;
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         n++;
         chk("hold_hi", hi, phi);
         chk("hold_lo", lo, plo);
         @(negedge clk);
      end
   endtask

   int n;
   logic [31:0] hi_m, lo_m;

   initial begin
      vecs[0] = '{"mult_neg2x3",   OP_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1] = '{"multu_max_x2",  OP_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
      vecs[2] = '{"div_neg7_2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{"divu_7_2",      OP_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
      vecs[4] = '{"div_overflow",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
      vecs[5] = '{"mult_7_neg3",   OP_MULT,  32'd7,        32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[6] = '{"div_7_neg2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
      vecs[7] = '{"mult_m1_m1",    OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001};
      vecs[8] = '{"multu_m1_m1",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
      vecs[9] = '{"div_neg8_neg3", OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 10, 32'hFFFFFFFE, 32'h00000002};

      rst = 1'b1; start = 1'b0; op = OP_DEF; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      op = OP_MFHI;
      #1;
      chk("reset_mfhi", res, 32'd0);
      op = OP_DEF;
      rst = 1'b0;

      hi_m = 32'd0; lo_m = 32'd0;
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi_m, lo_m, n);
         chk({vecs[i].name, "_cyc"}, n, vecs[i].cyc);
         chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
         chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
         hi_m = vecs[i].hi; lo_m = vecs[i].lo;
      end

      // mthi then mf reads, all zero-latency
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("rst2_lo", lo, 32'd0);
      run_op(OP_MTHI, 32'h1234, 32'd0, 32'd0, 32'd0, n);
      chk("mthi_cyc", n, 0);
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_lo", lo, 32'd0);
      op = OP_MFLO; start = 1'b1;
      #1;
      chk("mflo_res", res, 32'd0);
      op = OP_MFHI;
      #1;
      chk("mfhi_res", res, 32'h1234);
      @(posedge clk);
      #1;
      chk("mf_busy", {31'd0, busy}, 32'd0);
      chk("mf_hi", hi, 32'h1234);
      start = 1'b0; op = OP_DEF;

      run_op(OP_MTLO, 32'h55, 32'd0, 32'h1234, 32'd0, n);
      chk("mtlo_cyc", n, 0);
      chk("mtlo_lo", lo, 32'h55);

      // divide by zero, with mult and mthi attempted while busy
      @(negedge clk);
      op = OP_DIV; a = 32'd1; b = 32'd0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = OP_DEF;
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         n++;
         if (n == 3) begin
            op = OP_MULT; a = 32'd3; b = 32'd3; start = 1'b1;
         end else if (n == 5) begin
            op = OP_MTHI; a = 32'hFFFF; start = 1'b1;
         end else begin
            op = OP_DEF; start = 1'b0;
         end
         @(negedge clk);
      end
      op = OP_DEF; start = 1'b0;
      chk("div0_cyc", n, 10);
      chk("div0_hi", hi, 32'h1234);
      chk("div0_lo", lo, 32'h55);
      @(negedge clk);
      chk("div0_after_busy", {31'd0, busy}, 32'd0);

      // unknown op code with start: no effect
      op = 5'd9; a = 32'hDEAD; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op = OP_DEF;
      chk("defop_hi", hi, 32'h1234);
      chk("defop_lo", lo, 32'h55);
      chk("defop_busy", {31'd0, busy}, 32'd0);

      // reset during div busy cycle 3
      @(negedge clk);
      op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = OP_DEF;
      repeat (3) @(negedge clk);
      chk("midrst_busy_pre", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("midrst_late_busy", {31'd0, busy}, 32'd0);
      chk("midrst_late_hi", hi, 32'd0);
      chk("midrst_late_lo", lo, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
